// File: rtl/instr_mem_ctrl.sv
// Instruction memory with a valid/ready fetch port and a word-write load port.
// After reset it optionally zeroes every word, one per cycle, before it serves
// requests. Misaligned or out-of-range fetches return an error response
// instead of aliasing onto another word.
module instr_mem_ctrl #(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 4096,
    parameter int ADDR_W         = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              init_done,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic              rsp_err,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ack
);

    // Byte-lane shift: a word index is the byte address shifted right by BSH.
    localparam int BSH   = $clog2(DATA_W / 8);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'((1 << BSH) - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  clr_idx;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // True for an address that is not word aligned or lies past the last word.
    function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
        return ((a & LANE_MASK) != '0) || ((a >> BSH) >= DEPTH_A);
    endfunction

    // Word index of a byte address; only meaningful when addr_bad() is false.
    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] w;
        w = a >> BSH;
        return w[IDX_W-1:0];
    endfunction

    // A new fetch is taken whenever the response slot is empty or being drained.
    assign req_ready = (state == RUN) && (!rsp_valid || rsp_ready);

    // Single write port: the clear sweep owns it in CLEAR, the load port in RUN.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_idx;
        mem_wdata = '0;
        if (!rst) begin
            if (state == CLEAR) begin
                mem_we = 1'b1;
            end else if (ld_en && !addr_bad(ld_addr)) begin
                mem_we    = 1'b1;
                mem_waddr = word_idx(ld_addr);
                mem_wdata = ld_data;
            end
        end
    end

    // Synchronous write into the storage array.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Control FSM, registered fetch response and load acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            clr_idx   <= '0;
            init_done <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_instr <= '0;
            rsp_err   <= 1'b0;
            ld_ack    <= 1'b0;
        end else begin
            ld_ack <= ld_en && (state == RUN);

            case (state)
                CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == LAST_IDX) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                default: begin
                    init_done <= 1'b1;
                end
            endcase

            // The read sees the array before any same-edge load, so a fetch
            // and load to one word return the old contents.
            if (req_valid && req_ready) begin
                rsp_valid <= 1'b1;
                if (addr_bad(req_addr)) begin
                    rsp_err   <= 1'b1;
                    rsp_instr <= '0;
                end else begin
                    rsp_err   <= 1'b0;
                    rsp_instr <= mem[word_idx(req_addr)];
                end
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/instr_mem_ctrl.md
Name: instr_mem_ctrl

Overview:
Parametrised instruction memory with a valid/ready fetch port, a registered response, and a word-write load port for the boot loader or testbench. It replaces the combinational fixed-4096-word instruction ROM in the core's fetch stage. After reset it clears its own contents, one word per cycle. It flags misaligned and out-of-range fetches instead of silently aliasing them.

Parameters:
DATA_W, 32, instruction word width in bits; must be a power of two and at least 8.
DEPTH, 4096, number of words; must be a power of two.
ADDR_W, 32, byte-address width of the fetch and load ports.
CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = skip clearing and keep contents.

Ports:
clk  in  1  clock, all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
init_done  out  1  high once the memory is ready to serve requests.
req_valid  in  1  fetch request valid.
req_ready  out  1  fetch request accepted this cycle when high together with req_valid.
req_addr  in  ADDR_W  fetch byte address.
rsp_valid  out  1  response valid.
rsp_ready  in  1  consumer accepts the response.
rsp_instr  out  DATA_W  fetched word.
rsp_err  out  1  fetch was misaligned or out of range.
ld_en  in  1  load-write strobe, single-cycle.
ld_addr  in  ADDR_W  load byte address.
ld_data  in  DATA_W  load write data.
ld_ack  out  1  one-cycle pulse acknowledging a load.

Behaviour:
- Derived widths: BSH = log2(DATA_W/8); word index = addr >> BSH.
- Misaligned: addr[BSH-1:0] != 0. Out of range: index >= DEPTH.
- Reset (rst=1 at a clock edge) forces the following, regardless of state, including mid-transaction:
  - rsp_valid=0, rsp_instr=0, rsp_err=0, ld_ack=0, init_done=0, clr_idx=0.
  - state = CLEAR if CLEAR_ON_RESET=1, else RUN.
  - Any in-flight response is discarded.
- FSM states: CLEAR, RUN.
- CLEAR state:
  - Each cycle after rst deasserts, write 0 to mem[clr_idx] and increment clr_idx.
  - After writing index DEPTH-1, go to RUN on the next edge.
  - init_done rises exactly DEPTH cycles after the first cycle with rst=0.
  - req_ready=0 throughout. ld_en is ignored and produces no ld_ack.
- RUN state:
  - init_done=1.
  - If CLEAR_ON_RESET=0, RUN is entered directly and init_done=1 from the first cycle after rst deasserts.
- Fetch handshake:
  - req_ready = RUN && (!rsp_valid || rsp_ready). This is combinational, giving full throughput of one fetch per cycle.
  - On accept, the response registers load on that edge: rsp_valid=1, rsp_instr=mem[index], rsp_err=0. Latency is 1 cycle.
  - Misaligned or out-of-range fetch: rsp_err=1, rsp_instr=0, no memory access.
  - rsp_valid, rsp_instr and rsp_err hold stable while rsp_valid && !rsp_ready.
  - rsp_valid clears on rsp_ready when no new request is accepted in the same cycle.
- Load port (RUN only):
  - ld_en=1 writes mem[ld_index]=ld_data on that edge, and ld_ack=1 on the next cycle.
  - Misaligned or out-of-range load: no write, ld_ack still pulses.
  - Back-to-back loads are allowed, one per cycle.
- Fetch and load to the same word in the same cycle: read-before-write. The fetch returns the old data; the next fetch returns the new data.
- Fetch and load to different words in the same cycle: both complete independently.
- Storage is a single synchronous-write array of DEPTH×DATA_W bits with a registered read.

Test Plan:
1. DEPTH=16, CLEAR_ON_RESET=1, 1-cycle reset -> init_done=0 for 16 cycles, then 1; req_ready=0 throughout CLEAR; fetch of 0x0 returns 0x00000000 with rsp_err=0.
2. Load 0xDEADBEEF at 0x8, then fetch 0x8 with rsp_ready=1 -> ld_ack pulses for 1 cycle; next cycle rsp_valid=1, rsp_instr=0xDEADBEEF.
3. Back-to-back fetches 0x0, 0x4, 0x8 with rsp_ready held 0 for 3 cycles -> rsp_valid stays 1 with the first word stable; req_ready=0 while stalled; all three words are delivered in order once rsp_ready=1.
4. Fetch 0x6 (misaligned) and 0x40 (index 16, DEPTH=16) -> rsp_err=1 and rsp_instr=0 for each; memory is unchanged.
5. Same-cycle load 0x12345678 to 0xC and fetch 0xC -> response returns old data (0); a following fetch returns 0x12345678.
6. Assert rst while rsp_valid=1 and a load is pending -> next cycle rsp_valid=0, ld_ack=0, init_done=0; clearing restarts and a fetch after init_done returns 0.
